// File: rtl/job_seq_pkg.sv
// mytypes: shared worker-command and sequencer-state types for the job sequencer.
package mytypes;
  localparam int ACC_W = 8;
  typedef enum logic {start, done} mode_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
endpackage

// File: rtl/job_seq_acc.sv
// seq_acc: 8-bit wrapping accumulator with synchronous clear, enable and sticky overflow.
module seq_acc
  import mytypes::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] din,
  output logic [ACC_W-1:0] acc_o,
  output logic             ovf_o
);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;
  assign sum = {1'b0, acc_q} + {1'b0, din};
  always_comb begin
    acc_d = clr ? '0 : en ? sum[ACC_W-1:0] : acc_q;
    ovf_d = clr ? 1'b0 : en ? (ovf_q | sum[ACC_W]) : ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end
  assign acc_o = acc_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/job_seq.sv
// job_seq: runs one worker job of req_len cycles, accumulates worker samples and
// holds the result until the consumer handshakes it.
module job_seq
  import mytypes::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [LEN_W-1:0] req_len,
  output logic             req_ready,
  input  logic             abort,
  output mytypes::mode_t   mode,
  input  logic [ACC_W-1:0] wk_out,
  output logic             rsp_valid,
  output logic [ACC_W-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic             rsp_abort,
  input  logic             rsp_ready,
  output logic             busy,
  output logic [7:0]       jobs_done
);
  seq_state_t       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       jobs_q, jobs_d;
  logic             abort_q, abort_d;
  logic             clr, en;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    jobs_d  = jobs_q;
    abort_d = abort_q;
    clr     = 1'b0;
    en      = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        clr     = 1'b1;
        abort_d = 1'b0;
        cnt_d   = req_len;
        state_d = (req_len == '0) ? DONE : RUN;
      end
      // an aborted cycle leaves its sample out of the result
      RUN: if (abort) begin
        abort_d = 1'b1;
        state_d = DONE;
      end else begin
        en      = 1'b1;
        cnt_d   = cnt_q - LEN_W'(1);
        state_d = (cnt_q == LEN_W'(1)) ? DONE : RUN;
      end
      DONE: if (rsp_ready) begin
        state_d = IDLE;
        jobs_d  = jobs_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      jobs_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      jobs_q  <= jobs_d;
      abort_q <= abort_d;
    end
  end
  seq_acc u_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (en),
    .din  (wk_out),
    .acc_o(rsp_data),
    .ovf_o(rsp_ovf)
  );
  assign mode      = (state_q == RUN) ? start : done;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign rsp_abort = abort_q;
  assign jobs_done = jobs_q;
endmodule

// File: tb/tb_job_seq.sv
// tb_job_seq: directed jobs against a per-cycle expectation model derived from job
// descriptions (sample sums, cycle counts), plus literal pins on key results.
module tb_job_seq;
  import mytypes::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_len = '0;
  logic       req_ready;
  logic       abort = 1'b0;
  mode_t      mode;
  logic [7:0] wk_out = '0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ovf;
  logic       rsp_abort;
  logic       rsp_ready = 1'b0;
  logic       busy;
  logic [7:0] jobs_done;

  job_seq #(.LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_len(req_len),
    .req_ready(req_ready), .abort(abort), .mode(mode), .wk_out(wk_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
    .rsp_abort(rsp_abort), .rsp_ready(rsp_ready), .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic       chk_on = 1'b0;
  logic       exp_ready = 1'b1, exp_valid = 1'b0, exp_busy = 1'b0, exp_ovf = 1'b0, exp_ab = 1'b0;
  mode_t      exp_mode = done;
  logic [7:0] exp_data = '0, exp_jobs = '0;
  int         wk[8];
  int         starts, got_data, got_ovf, got_ab;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("req_ready", req_ready, exp_ready);
    chk("mode", mode, exp_mode);
    chk("rsp_valid", rsp_valid, exp_valid);
    chk("busy", busy, exp_busy);
    chk("jobs_done", jobs_done, exp_jobs);
    if (exp_valid) begin
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_ovf", rsp_ovf, exp_ovf);
      chk("rsp_abort", rsp_abort, exp_ab);
    end
  end

  // ab: 1-based RUN cycle carrying abort (0 = none); stall: DONE cycles before rsp_ready
  task automatic run_job(input int len, input int ab, input int stall);
    int r, k, sum;
    r = (ab != 0) ? ab : len;
    k = (ab != 0) ? ab - 1 : len;
    sum = 0;
    for (int i = 0; i < k; i++) sum += wk[i];
    starts = 0;
    req_valid = 1'b1;
    req_len = 8'(len);
    abort = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < r; i++) begin
      wk_out = 8'(wk[i]);
      abort = (i == ab - 1);
      exp_ready = 1'b0; exp_mode = start; exp_valid = 1'b0; exp_busy = 1'b1;
      @(negedge clk);
      if (mode == start) starts++;
      @(posedge clk); #1;
    end
    abort = 1'b1;
    req_valid = 1'b1;
    req_len = 8'd4;
    wk_out = 8'd0;
    exp_mode = done; exp_valid = 1'b1; exp_busy = 1'b1; exp_ready = 1'b0;
    exp_data = 8'(sum); exp_ovf = (sum > 255); exp_ab = (ab != 0);
    for (int i = 0; i <= stall; i++) begin
      rsp_ready = (i == stall);
      if (i == 0) begin
        @(negedge clk);
        got_data = rsp_data; got_ovf = rsp_ovf; got_ab = rsp_abort;
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0; req_valid = 1'b0; abort = 1'b0;
    exp_jobs++;
    exp_ready = 1'b1; exp_valid = 1'b0; exp_busy = 1'b0; exp_mode = done;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_data", rsp_data, 0);
    chk("rst_ovf", rsp_ovf, 0);
    chk("rst_abort", rsp_abort, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wk = '{10, 20, 30, 0, 0, 0, 0, 0};
    run_job(3, 0, 0);
    chk("j1_starts", starts, 3);
    chk("j1_data", got_data, 60);
    chk("j1_ovf", got_ovf, 0);
    wk = '{200, 100, 0, 0, 0, 0, 0, 0};
    run_job(2, 0, 0);
    chk("j2_data", got_data, 44);
    chk("j2_ovf", got_ovf, 1);
    run_job(0, 0, 0);
    chk("j3_starts", starts, 0);
    chk("j3_data", got_data, 0);
    wk = '{5, 6, 99, 1, 1, 0, 0, 0};
    run_job(5, 3, 0);
    chk("j4_starts", starts, 3);
    chk("j4_data", got_data, 11);
    chk("j4_abort", got_ab, 1);
    @(negedge clk);
    chk("j4_jobs", jobs_done, 4);
    wk = '{7, 8, 0, 0, 0, 0, 0, 0};
    run_job(2, 0, 10);
    chk("stall_data", got_data, 15);
    wk = '{200, 55, 0, 0, 0, 0, 0, 0};
    run_job(2, 0, 1);
    chk("b255_data", got_data, 255);
    chk("b255_ovf", got_ovf, 0);
    wk = '{64, 64, 64, 64, 0, 0, 0, 0};
    run_job(4, 0, 0);
    chk("b256_data", got_data, 0);
    chk("b256_ovf", got_ovf, 1);
    chk_on = 1'b0;
    req_valid = 1'b1; req_len = 8'd5;
    @(posedge clk); #1;
    req_valid = 1'b0; wk_out = 8'd9;
    @(posedge clk); #2;
    chk("pre_rst_mode", mode, start);
    rst_n = 1'b0;
    #1;
    chk("arst_mode", mode, done);
    chk("arst_valid", rsp_valid, 0);
    chk("arst_ready", req_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_jobs", jobs_done, 0);
    chk("arst_data", rsp_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_jobs = '0;
    exp_ready = 1'b1; exp_valid = 1'b0; exp_busy = 1'b0; exp_mode = done;
    chk_on = 1'b1;
    wk = '{1, 2, 3, 0, 0, 0, 0, 0};
    run_job(3, 0, 0);
    chk("post_rst_data", got_data, 6);
    for (int j = 0; j < 255; j++) run_job(0, 0, 0);
    @(negedge clk);
    chk("wrap_jobs", jobs_done, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
